// File: rtl/admo_alu_arbiter_pkg.sv
// Shared types and constants for the two-port ALU arbiter and its ALU.
package admo_alu_arbiter_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned OP_W       = 4;

  localparam logic [OP_W-1:0] ALU_ADD = 4'h0;
  localparam logic [OP_W-1:0] ALU_SUB = 4'h1;
  localparam logic [OP_W-1:0] ALU_AND = 4'h2;
  localparam logic [OP_W-1:0] ALU_OR  = 4'h3;
  localparam logic [OP_W-1:0] ALU_XOR = 4'h4;

  typedef enum logic {
    ARB_ST_IDLE = 1'b0,
    ARB_ST_RESP = 1'b1
  } arb_state_e;

  function automatic logic alu_op_legal(input logic [OP_W-1:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/admo_alu_arbiter_alu.sv
// Combinational ALU: wrapping add/sub and bitwise ops; undefined codes yield zero.
module admo_alu_arbiter_alu
  import admo_alu_arbiter_pkg::*;
#(
  parameter int unsigned DW     = DATA_WIDTH,
  parameter int unsigned CHK_OP = 1
) (
  input  logic [OP_W-1:0] op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [DW-1:0]   res_c,
  output logic            err_c
);

  always_comb begin
    res_c = '0;
    err_c = 1'b0;
    case (op)
      ALU_ADD: res_c = a + b;
      ALU_SUB: res_c = a - b;
      ALU_AND: res_c = a & b;
      ALU_OR:  res_c = a | b;
      ALU_XOR: res_c = a ^ b;
      default: err_c = (CHK_OP != 0);
    endcase
  end

endmodule

// File: rtl/admo_alu_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters, one op in flight.
module admo_alu_arbiter
  import admo_alu_arbiter_pkg::*;
#(
  parameter int unsigned DW     = DATA_WIDTH,
  parameter int unsigned CHK_OP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OP_W-1:0] req0_op,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [DW-1:0]   rsp0_res,
  output logic            rsp0_err,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OP_W-1:0] req1_op,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [DW-1:0]   rsp1_res,
  output logic            rsp1_err
);

  arb_state_e      state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic [DW-1:0]   res_q, res_d;
  logic            err_q, err_d;

  logic            retire;
  logic            grant_en;
  logic            grant;
  logic [OP_W-1:0] alu_op;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [DW-1:0]   alu_res;
  logic            alu_err;

  admo_alu_arbiter_alu #(
    .DW     (DW),
    .CHK_OP (CHK_OP)
  ) u_alu (
    .op    (alu_op),
    .a     (alu_a),
    .b     (alu_b),
    .res_c (alu_res),
    .err_c (alu_err)
  );

  // Grant window: idle, or the owner is retiring its response this cycle.
  always_comb begin
    retire   = (state_q == ARB_ST_RESP) && (owner_q ? rsp1_ready : rsp0_ready);
    grant    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
    grant_en   = !rst && (req0_valid || req1_valid) &&
                 ((state_q == ARB_ST_IDLE) || retire);
    req0_ready = grant_en && !grant;
    req1_ready = grant_en && grant;
    alu_op     = grant ? req1_op : req0_op;
    alu_a      = grant ? req1_a  : req0_a;
    alu_b      = grant ? req1_b  : req0_b;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    res_d        = res_q;
    err_d        = err_q;
    if (grant_en) begin
      state_d      = ARB_ST_RESP;
      owner_d      = grant;
      last_grant_d = grant;
      res_d        = alu_res;
      err_d        = alu_err;
    end else if (retire) begin
      state_d = ARB_ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      res_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      res_q        <= res_d;
      err_q        <= err_d;
    end
  end

  assign rsp0_valid = (state_q == ARB_ST_RESP) && !owner_q;
  assign rsp1_valid = (state_q == ARB_ST_RESP) && owner_q;
  assign rsp0_res   = res_q;
  assign rsp1_res   = res_q;
  assign rsp0_err   = err_q;
  assign rsp1_err   = err_q;

endmodule

// File: tb/tb_admo_alu_arbiter.sv
// Directed bench for admo_alu_arbiter: arbitration, back-pressure, wrap, undefined ops, reset.
module tb_admo_alu_arbiter;
  import admo_alu_arbiter_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
  logic            req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
  logic [OP_W-1:0] req0_op, req1_op;
  logic [31:0]     req0_a, req0_b, req1_a, req1_b, rsp0_res, rsp1_res;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  admo_alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_res   (rsp0_res),
    .rsp0_err   (rsp0_err),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_res   (rsp1_res),
    .rsp1_err   (rsp1_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  initial begin
    rst = 1'b1;
    set0(1'b0, ALU_ADD, 32'h0, 32'h0);
    set1(1'b0, ALU_ADD, 32'h0, 32'h0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    tick(); tick();
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'h0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'h0);
    chk("rst_res", rsp0_res, 32'h0);
    chk("rst_err", 32'(rsp0_err), 32'h0);
    chk("rst_req0_ready", 32'(req0_ready), 32'h0);

    // 1: single ADD
    rst = 1'b0;
    set0(1'b1, ALU_ADD, 32'd5, 32'd3);
    #1;
    chk("t1_req0_ready", 32'(req0_ready), 32'h1);
    chk("t1_req1_ready", 32'(req1_ready), 32'h0);
    tick();
    set0(1'b0, ALU_ADD, 32'h0, 32'h0);
    rsp0_ready = 1'b1;
    chk("t1_rsp0_valid", 32'(rsp0_valid), 32'h1);
    chk("t1_res", rsp0_res, 32'd8);
    chk("t1_err", 32'(rsp0_err), 32'h0);
    tick();
    chk("t1_idle_rsp0_valid", 32'(rsp0_valid), 32'h0);

    // 2: ties after reset alternate, starting with port 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp1_ready = 1'b1;
    set0(1'b1, ALU_SUB, 32'd10, 32'd3);
    set1(1'b1, ALU_XOR, 32'hF0, 32'h0F);
    #1;
    chk("t2_tie1_req0_ready", 32'(req0_ready), 32'h1);
    chk("t2_tie1_req1_ready", 32'(req1_ready), 32'h0);
    tick();
    set0(1'b0, ALU_ADD, 32'h0, 32'h0);
    chk("t2_rsp0_valid", 32'(rsp0_valid), 32'h1);
    chk("t2_res0", rsp0_res, 32'd7);
    #1;
    chk("t2_b2b_req1_ready", 32'(req1_ready), 32'h1);
    tick();
    chk("t2_rsp1_valid", 32'(rsp1_valid), 32'h1);
    chk("t2_rsp0_valid_low", 32'(rsp0_valid), 32'h0);
    chk("t2_res1", rsp1_res, 32'h0000_00FF);
    set0(1'b1, ALU_ADD, 32'd1, 32'd2);
    set1(1'b1, ALU_AND, 32'hFF, 32'h3C);
    #1;
    chk("t2_tie3_req0_ready", 32'(req0_ready), 32'h1);
    chk("t2_tie3_req1_ready", 32'(req1_ready), 32'h0);
    rsp0_ready = 1'b0;
    tick();
    set0(1'b0, ALU_ADD, 32'h0, 32'h0);
    set1(1'b1, ALU_OR, 32'h0C, 32'h03);
    chk("t2_res3", rsp0_res, 32'd3);

    // 3: back-pressure on port 0 while port 1 waits
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_hold_req1_ready", 32'(req1_ready), 32'h0);
      chk("t3_hold_rsp0_valid", 32'(rsp0_valid), 32'h1);
      chk("t3_hold_res", rsp0_res, 32'd3);
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    chk("t3_retire_req1_ready", 32'(req1_ready), 32'h1);
    tick();
    set1(1'b0, ALU_ADD, 32'h0, 32'h0);
    chk("t3_rsp1_valid", 32'(rsp1_valid), 32'h1);
    chk("t3_res", rsp1_res, 32'h0F);
    tick();
    chk("t3_idle", 32'(rsp1_valid), 32'h0);

    // 4: wrap-around
    set0(1'b1, ALU_SUB, 32'd0, 32'd1);
    tick();
    chk("t4_sub_res", rsp0_res, 32'hFFFF_FFFF);
    chk("t4_sub_err", 32'(rsp0_err), 32'h0);
    set0(1'b1, ALU_ADD, 32'hFFFF_FFFF, 32'd1);
    #1;
    chk("t4_b2b_req0_ready", 32'(req0_ready), 32'h1);
    tick();
    chk("t4_add_valid", 32'(rsp0_valid), 32'h1);
    chk("t4_add_res", rsp0_res, 32'h0);
    chk("t4_add_err", 32'(rsp0_err), 32'h0);

    // 5: undefined opcode, then a legal op clears the error
    set0(1'b1, 4'hF, 32'd1, 32'd2);
    tick();
    chk("t5_undef_res", rsp0_res, 32'h0);
    chk("t5_undef_err", 32'(rsp0_err), 32'h1);
    set0(1'b1, ALU_AND, 32'hFF, 32'h0F);
    tick();
    set0(1'b0, ALU_ADD, 32'h0, 32'h0);
    chk("t5_legal_res", rsp0_res, 32'h0F);
    chk("t5_legal_err", 32'(rsp0_err), 32'h0);
    tick();
    chk("t5_idle", 32'(rsp0_valid), 32'h0);

    // 6: reset while a response is pending
    rsp1_ready = 1'b0;
    set1(1'b1, ALU_ADD, 32'd2, 32'd2);
    tick();
    chk("t6_pending_valid", 32'(rsp1_valid), 32'h1);
    chk("t6_pending_res", rsp1_res, 32'd4);
    rst = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    chk("t6_rst_req1_ready", 32'(req1_ready), 32'h0);
    tick();
    chk("t6_rst_rsp1_valid", 32'(rsp1_valid), 32'h0);
    chk("t6_rst_rsp0_valid", 32'(rsp0_valid), 32'h0);
    chk("t6_rst_res", rsp1_res, 32'h0);
    rst = 1'b0;
    set0(1'b1, ALU_ADD, 32'd1, 32'd1);
    #1;
    chk("t6_tie_req0_ready", 32'(req0_ready), 32'h1);
    chk("t6_tie_req1_ready", 32'(req1_ready), 32'h0);
    tick();
    set0(1'b0, ALU_ADD, 32'h0, 32'h0);
    set1(1'b0, ALU_ADD, 32'h0, 32'h0);
    chk("t6_rsp0_valid", 32'(rsp0_valid), 32'h1);
    chk("t6_res", rsp0_res, 32'd2);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
